// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - fetch/data arbiter in front of one unified single-port SRAM
module unified_mem_arbiter #(
    parameter int AWIDTH   = 10,
    parameter int MAX_WAIT = 4
) (
    input  logic              CLK,
    input  logic              RST,
    // instruction fetch port
    input  logic              I_REQ,
    input  logic [AWIDTH+1:0] I_ADDR,
    output logic              I_ACK,
    output logic              I_RVALID,
    output logic [31:0]       I_RDATA,
    // data load/store port
    input  logic              D_REQ,
    input  logic              D_WE,
    input  logic [3:0]        D_BE,
    input  logic [AWIDTH+1:0] D_ADDR,
    input  logic [31:0]       D_WDATA,
    output logic              D_ACK,
    output logic              D_RVALID,
    output logic [31:0]       D_RDATA,
    // single-port SRAM
    output logic              M_CSN,
    output logic              M_WEN,
    output logic [3:0]        M_BE,
    output logic [AWIDTH-1:0] M_ADDR,
    output logic [31:0]       M_DI,
    input  logic [31:0]       M_DOUT,
    // performance counter
    output logic [31:0]       I_STALL_CNT
);

    // Fetch gets priority once it has been denied this many cycles in a row.
    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    // Who owns the SRAM read data that appears in the current cycle.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

    owner_e      rd_owner_q, rd_owner_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic [31:0] i_hold_q, i_hold_d;
    logic [31:0] d_hold_q, d_hold_d;
    logic [31:0] stall_q, stall_d;
    logic        grant_i;
    logic        grant_d;
    logic        i_denied;

    // Grant selection: data wins unless fetch has aged past MAX_WAIT; nothing while in reset.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (!RST) begin
            if (I_REQ && (!D_REQ || (wait_cnt_q >= MAX_WAIT_C))) begin
                grant_i = 1'b1;
            end else if (D_REQ) begin
                grant_d = 1'b1;
            end
        end
    end

    assign I_ACK    = grant_i;
    assign D_ACK    = grant_d;
    assign i_denied = I_REQ & ~grant_i;

    // SRAM command for the granted requester; a fetch is always a read.
    always_comb begin
        M_CSN  = ~(grant_i | grant_d);
        M_WEN  = 1'b1;
        M_BE   = 4'b0000;
        M_ADDR = I_ADDR[AWIDTH+1:2];
        M_DI   = D_WDATA;
        if (grant_d) begin
            M_ADDR = D_ADDR[AWIDTH+1:2];
            M_WEN  = ~D_WE;
            M_BE   = D_WE ? D_BE : 4'b0000;
        end
    end

    // Next-state: aging counter, response owner, held read data, stall counter.
    always_comb begin
        if (i_denied) begin
            wait_cnt_d = (wait_cnt_q == 4'hF) ? 4'hF : (wait_cnt_q + 4'd1);
        end else begin
            wait_cnt_d = 4'd0;
        end

        if (grant_i) begin
            rd_owner_d = OWN_I;
        end else if (grant_d && !D_WE) begin
            rd_owner_d = OWN_D;
        end else begin
            rd_owner_d = OWN_NONE;
        end

        i_hold_d = (rd_owner_q == OWN_I) ? M_DOUT : i_hold_q;
        d_hold_d = (rd_owner_q == OWN_D) ? M_DOUT : d_hold_q;
        stall_d  = stall_q + {31'd0, i_denied};
    end

    // State registers; reset discards any in-flight response immediately.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd_owner_q <= OWN_NONE;
            wait_cnt_q <= 4'd0;
            i_hold_q   <= 32'd0;
            d_hold_q   <= 32'd0;
            stall_q    <= 32'd0;
        end else begin
            rd_owner_q <= rd_owner_d;
            wait_cnt_q <= wait_cnt_d;
            i_hold_q   <= i_hold_d;
            d_hold_q   <= d_hold_d;
            stall_q    <= stall_d;
        end
    end

    // Response steering: SRAM data passes straight through in the response cycle, then is held.
    assign I_RVALID    = (rd_owner_q == OWN_I);
    assign D_RVALID    = (rd_owner_q == OWN_D);
    assign I_RDATA     = I_RVALID ? M_DOUT : i_hold_q;
    assign D_RDATA     = D_RVALID ? M_DOUT : d_hold_q;
    assign I_STALL_CNT = stall_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb/tb_unified_mem_arbiter.sv - scoreboard bench for unified_mem_arbiter
module tb_unified_mem_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic        I_REQ;
    logic [11:0] I_ADDR;
    logic        I_ACK, I_RVALID;
    logic [31:0] I_RDATA;
    logic        D_REQ, D_WE;
    logic [3:0]  D_BE;
    logic [11:0] D_ADDR;
    logic [31:0] D_WDATA;
    logic        D_ACK, D_RVALID;
    logic [31:0] D_RDATA;
    logic        M_CSN, M_WEN;
    logic [3:0]  M_BE;
    logic [9:0]  M_ADDR;
    logic [31:0] M_DI;
    logic [31:0] M_DOUT;
    logic [31:0] I_STALL_CNT;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] sram    [1024];
    logic [31:0] ref_mem [1024];
    logic [31:0] iq [$];
    logic [31:0] dq [$];

    unified_mem_arbiter #(.AWIDTH(10), .MAX_WAIT(4)) dut (
        .CLK(CLK), .RST(RST),
        .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_ACK(I_ACK), .I_RVALID(I_RVALID), .I_RDATA(I_RDATA),
        .D_REQ(D_REQ), .D_WE(D_WE), .D_BE(D_BE), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA),
        .D_ACK(D_ACK), .D_RVALID(D_RVALID), .D_RDATA(D_RDATA),
        .M_CSN(M_CSN), .M_WEN(M_WEN), .M_BE(M_BE), .M_ADDR(M_ADDR), .M_DI(M_DI), .M_DOUT(M_DOUT),
        .I_STALL_CNT(I_STALL_CNT)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] preset_word(input int k);
        case (k)
            0:       return 32'h0000_0011;
            1:       return 32'h0000_0022;
            2:       return 32'h0000_0033;
            4:       return 32'h0000_0000;
            8:       return 32'h5A5A_5A5A;
            default: return 32'hA000_0000 | k;
        endcase
    endfunction

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // SRAM model, driven only from the M_* side.
    initial begin
        for (int k = 0; k < 1024; k++) sram[k] = preset_word(k);
        M_DOUT = 32'd0;
        forever begin
            @(posedge CLK);
            if (!M_CSN) begin
                M_DOUT <= sram[M_ADDR];
                if (!M_WEN) begin
                    for (int b = 0; b < 4; b++)
                        if (M_BE[b]) sram[M_ADDR][8*b +: 8] = M_DI[8*b +: 8];
                end
            end
        end
    end

    // Scoreboard: responses are checked against the requester-side reference memory.
    initial begin
        logic [31:0] e;
        for (int k = 0; k < 1024; k++) ref_mem[k] = preset_word(k);
        forever begin
            @(negedge CLK);
            if (RST) begin
                iq.delete();
                dq.delete();
            end else begin
                expect_eq("single_ack", {31'd0, I_ACK & D_ACK}, 32'd0);
                if (I_RVALID) begin
                    expect_eq("i_rsp_pending", {31'd0, iq.size() > 0}, 32'd1);
                    if (iq.size() > 0) begin
                        e = iq.pop_front();
                        expect_eq("i_rdata_sb", I_RDATA, e);
                    end
                end
                if (D_RVALID) begin
                    expect_eq("d_rsp_pending", {31'd0, dq.size() > 0}, 32'd1);
                    if (dq.size() > 0) begin
                        e = dq.pop_front();
                        expect_eq("d_rdata_sb", D_RDATA, e);
                    end
                end
                if (I_ACK) iq.push_back(ref_mem[I_ADDR[11:2]]);
                if (D_ACK) begin
                    if (D_WE) begin
                        for (int b = 0; b < 4; b++)
                            if (D_BE[b]) ref_mem[D_ADDR[11:2]][8*b +: 8] = D_WDATA[8*b +: 8];
                    end else begin
                        dq.push_back(ref_mem[D_ADDR[11:2]]);
                    end
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        I_REQ = 1'b0;
        D_REQ = 1'b0;
        D_WE  = 1'b0;
        D_BE  = 4'b0000;
    endtask

    initial begin
        RST = 1'b1;
        I_REQ = 1'b1; I_ADDR = 12'h000;
        D_REQ = 1'b1; D_WE = 1'b0; D_BE = 4'b0000; D_ADDR = 12'h000; D_WDATA = 32'd0;

        // reset state with both requests asserted
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        expect_eq("rst_csn", {31'd0, M_CSN}, 32'd1);
        expect_eq("rst_wen", {31'd0, M_WEN}, 32'd1);
        expect_eq("rst_be", {28'd0, M_BE}, 32'd0);
        expect_eq("rst_iack", {31'd0, I_ACK}, 32'd0);
        expect_eq("rst_dack", {31'd0, D_ACK}, 32'd0);
        expect_eq("rst_rvalid", {30'd0, I_RVALID, D_RVALID}, 32'd0);
        expect_eq("rst_rdata", I_RDATA | D_RDATA, 32'd0);
        expect_eq("rst_stall", I_STALL_CNT, 32'd0);

        // fetch only, back to back
        next_cycle();
        RST = 1'b0;
        idle();
        for (int c = 0; c < 4; c++) begin
            I_REQ  = (c < 3);
            I_ADDR = 12'(4 * c);
            @(negedge CLK);
            if (c < 3) expect_eq("fetch_ack", {31'd0, I_ACK}, 32'd1);
            if (c > 0) begin
                expect_eq("fetch_rvalid", {31'd0, I_RVALID}, 32'd1);
                expect_eq("fetch_rdata", I_RDATA, 32'h11 * c);
            end
            next_cycle();
        end
        expect_eq("fetch_stall", I_STALL_CNT, 32'd0);

        // partial store then load of the same word
        D_REQ = 1'b1; D_WE = 1'b1; D_BE = 4'b0011; D_ADDR = 12'h010; D_WDATA = 32'hDEAD_BEEF;
        @(negedge CLK);
        expect_eq("st_ack", {31'd0, D_ACK}, 32'd1);
        expect_eq("st_wen", {31'd0, M_WEN}, 32'd0);
        expect_eq("st_be", {28'd0, M_BE}, 32'h3);
        expect_eq("st_addr", {22'd0, M_ADDR}, 32'h4);
        next_cycle();
        D_WE = 1'b0;
        @(negedge CLK);
        expect_eq("ld_ack", {31'd0, D_ACK}, 32'd1);
        expect_eq("ld_wen", {31'd0, M_WEN}, 32'd1);
        expect_eq("st_no_rvalid", {30'd0, I_RVALID, D_RVALID}, 32'd0);
        next_cycle();
        idle();
        @(negedge CLK);
        expect_eq("ld_rvalid", {31'd0, D_RVALID}, 32'd1);
        expect_eq("ld_rdata", D_RDATA, 32'h0000_BEEF);
        expect_eq("ld_no_ivalid", {31'd0, I_RVALID}, 32'd0);
        next_cycle();

        // contention: four data grants, then the aged fetch, then data again
        for (int c = 0; c < 6; c++) begin
            D_REQ = 1'b1; D_WE = 1'b0; D_ADDR = 12'(12'h200 + 4 * c);
            I_REQ = (c < 5); I_ADDR = 12'h100;
            @(negedge CLK);
            expect_eq("cont_dack", {31'd0, D_ACK}, {31'd0, c != 4});
            expect_eq("cont_iack", {31'd0, I_ACK}, {31'd0, c == 4});
            next_cycle();
        end
        idle();
        @(negedge CLK);
        expect_eq("cont_stall", I_STALL_CNT, 32'd4);
        next_cycle();

        // interleaved responses I, D, I
        for (int c = 0; c < 4; c++) begin
            idle();
            if (c == 0) begin I_REQ = 1'b1; I_ADDR = 12'h000; end
            if (c == 1) begin D_REQ = 1'b1; D_ADDR = 12'h024; end
            if (c == 2) begin I_REQ = 1'b1; I_ADDR = 12'h008; end
            @(negedge CLK);
            expect_eq("intl_ivalid", {31'd0, I_RVALID}, {31'd0, c == 1 || c == 3});
            expect_eq("intl_dvalid", {31'd0, D_RVALID}, {31'd0, c == 2});
            if (c == 2) expect_eq("intl_drdata", D_RDATA, 32'hA000_0009);
            if (c == 3) expect_eq("intl_irdata", I_RDATA, 32'h0000_0033);
            next_cycle();
        end

        // reset in the cycle after a load is accepted
        D_REQ = 1'b1; D_WE = 1'b0; D_ADDR = 12'h00C;
        @(negedge CLK);
        expect_eq("mid_ack", {31'd0, D_ACK}, 32'd1);
        next_cycle();
        RST = 1'b1; I_REQ = 1'b1;
        @(negedge CLK);
        expect_eq("mid_rvalid", {31'd0, D_RVALID}, 32'd0);
        expect_eq("mid_csn", {31'd0, M_CSN}, 32'd1);
        expect_eq("mid_acks", {30'd0, I_ACK, D_ACK}, 32'd0);
        expect_eq("mid_stall", I_STALL_CNT, 32'd0);
        next_cycle();
        next_cycle();
        RST = 1'b0; I_REQ = 1'b0;
        @(negedge CLK);
        expect_eq("post_rst_ack", {31'd0, D_ACK}, 32'd1);
        next_cycle();
        idle();
        @(negedge CLK);
        expect_eq("post_rst_rvalid", {31'd0, D_RVALID}, 32'd1);
        expect_eq("post_rst_rdata", D_RDATA, 32'hA000_0003);
        next_cycle();

        // store with no byte enables leaves memory untouched
        D_REQ = 1'b1; D_WE = 1'b1; D_BE = 4'b0000; D_ADDR = 12'h020; D_WDATA = 32'hFFFF_FFFF;
        @(negedge CLK);
        expect_eq("zbe_ack", {31'd0, D_ACK}, 32'd1);
        expect_eq("zbe_be", {28'd0, M_BE}, 32'd0);
        next_cycle();
        D_WE = 1'b0;
        @(negedge CLK);
        expect_eq("zbe_no_rvalid", {31'd0, D_RVALID}, 32'd0);
        next_cycle();
        idle();
        @(negedge CLK);
        expect_eq("zbe_rvalid", {31'd0, D_RVALID}, 32'd1);
        expect_eq("zbe_rdata", D_RDATA, 32'h5A5A_5A5A);
        next_cycle();

        @(negedge CLK);
        expect_eq("iq_drained", iq.size(), 32'd0);
        expect_eq("dq_drained", dq.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-port SRAM between the core's instruction-fetch port and its data load/store port.
- Replaces the separate I-memory and D-memory instances with one unified memory. The arbiter sits between RISCV_TOP's I/D memory interfaces and one SP_SRAM instance.
- Per cycle, grants at most one access. Data has priority by default, and an aging counter bounds instruction-fetch starvation.
- Routes each one-cycle-latency read response back to the requester that issued it, and counts fetch stall cycles for performance reporting.

Parameters:
- AWIDTH, 10, SRAM word-address width. Byte-address ports are AWIDTH+2 bits wide.
- MAX_WAIT, 4, number of consecutive denied cycles after which a pending fetch gets priority. Legal range is 1..15.

Ports:
- CLK  in  1  clock; all state updates on the rising edge
- RST  in  1  asynchronous, active-high reset
- I_REQ  in  1  fetch request; held high with I_ADDR stable until I_ACK
- I_ADDR  in  AWIDTH+2  fetch byte address; bits [1:0] ignored
- I_ACK  out  1  fetch accepted this cycle (combinational)
- I_RVALID  out  1  fetch data valid, one cycle after I_ACK
- I_RDATA  out  32  fetch data
- D_REQ  in  1  data request; held high with D_WE, D_BE, D_ADDR and D_WDATA stable until D_ACK
- D_WE  in  1  1 = store, 0 = load
- D_BE  in  4  store byte enables
- D_ADDR  in  AWIDTH+2  data byte address; bits [1:0] ignored
- D_WDATA  in  32  store data
- D_ACK  out  1  data access accepted this cycle (combinational)
- D_RVALID  out  1  load data valid, one cycle after D_ACK with D_WE=0
- D_RDATA  out  32  load data
- M_CSN  out  1  SRAM chip select, active low
- M_WEN  out  1  SRAM write enable, active low
- M_BE  out  4  SRAM byte enables
- M_ADDR  out  AWIDTH  SRAM word address
- M_DI  out  32  SRAM write data
- M_DOUT  in  32  SRAM read data, valid the cycle after the access
- I_STALL_CNT  out  32  count of cycles where I_REQ=1 and I_ACK=0

Behaviour:
- Reset (asynchronous, takes effect immediately on RST):
  - wait_cnt=0; I_RVALID and D_RVALID forced to 0; any in-flight read response is discarded.
  - I_RDATA and D_RDATA go to 0; I_STALL_CNT goes to 0.
  - M_CSN=1, M_WEN=1, M_BE=0, I_ACK=0, D_ACK=0 for as long as RST is high.
- Arbitration is combinational from REQ inputs and registered wait_cnt; the result is "grant":
  - only I_REQ: grant I.
  - only D_REQ: grant D.
  - both, and wait_cnt >= MAX_WAIT: grant I.
  - both, otherwise: grant D.
  - neither: no grant; M_CSN=1.
- Granted cycle:
  - M_CSN=0, M_ADDR = granted address [AWIDTH+1:2], matching ACK = 1.
  - I grant: M_WEN=1, M_BE=0.
  - D grant: M_WEN = ~D_WE; M_BE = D_WE ? D_BE : 0; M_DI = D_WDATA.
  - A D_WE=1 grant with D_BE=0 is still issued and acked; memory is unchanged.
- wait_cnt (4-bit, saturating at 15):
  - increments when I_REQ=1 and I_ACK=0;
  - clears to 0 when I_ACK=1 or I_REQ=0.
- Response path:
  - Registered owner flag rd_owner ∈ {NONE, I, D} is set on each read grant; a store grant or no grant sets NONE.
  - The next cycle raises exactly one of I_RVALID or D_RVALID for one cycle.
  - The matching RDATA is loaded from M_DOUT and held until the next response to that port.
- Pipelining: back-to-back grants every cycle are legal, with no bubble.
  - Example: an I grant in cycle t and a D load grant in t+1 give I_RVALID in t+1 and D_RVALID in t+2.
- I_STALL_CNT increments by 1 each cycle with I_REQ & ~I_ACK and wraps at 2^32.
- A requester dropping REQ without ACK is tolerated: nothing is issued and wait_cnt clears.
- The arbiter never drives both ACKs high in the same cycle.

Test Plan:
- Fetch only: I_REQ=1 with I_ADDR=0x000, 0x004, 0x008 on consecutive cycles, SRAM preloaded 0x11,0x22,0x33 → I_ACK=1 every cycle; I_RDATA 0x11, 0x22, 0x33 on the following cycles; I_STALL_CNT=0.
- Store then load: D store to 0x010 with D_WDATA=0xDEADBEEF and D_BE=4'b0011, then a load from 0x010 → M_WEN=0 and M_BE=0011 on the store; D_RVALID with D_RDATA=0x0000BEEF (memory preset 0); I_RVALID stays 0.
- Contention with MAX_WAIT=4: I_REQ and D_REQ held high, D address changing every cycle → D granted for 4 cycles, I granted in the 5th, then D again; I_STALL_CNT=4.
- Interleaved responses: I grant in cycle t, D load in t+1, I grant in t+2 → RVALID pattern I, D, I on t+1..t+3, each carrying its own address's data.
- Reset mid-read: RST asserted the cycle after a D load ACK → D_RVALID stays 0, M_CSN=1 immediately, I_STALL_CNT=0. After release, the first request is granted normally.
- Zero-BE store: D_WE=1, D_BE=0 at 0x020, which holds 0x5A5A5A5A → D_ACK=1, no RVALID, later load returns 0x5A5A5A5A.
